// File: rtl/sint_slice_acc.sv
// Signed slice accumulator: sums sext(A field)+sext(B field) over COUNT samples and holds the result.
// Optional build macro SINT_SLICE_ACC_SAT_EN clamps XOUT to the OUT_W signed range and flags OVF.
module sint_slice_acc #(
    parameter int WIDTH   = 8,
    parameter int SLICE_W = 4,
    parameter int LO_A    = 0,
    parameter int LO_B    = 1,
    parameter int OUT_W   = 4,
    parameter int COUNT   = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic signed [OUT_W-1:0] XOUT,
    output logic                    OVF
);

    localparam int TERM_W = SLICE_W + 1;
    localparam int ACC_W  = SLICE_W + 1 + $clog2(COUNT);
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int CNT_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [OUT_W-1:0]   xout_q, xout_d;
    logic                      ovf_q, ovf_d;

    logic signed [SLICE_W-1:0] fa_s;
    logic signed [SLICE_W-1:0] fb_s;
    logic signed [TERM_W-1:0]  term_s;
    logic signed [ACC_W-1:0]   acc_sum_s;
    logic                      unused_in_s;

    // Wrap mapping: sign-extend first so OUT_W wider than the accumulator still works.
    function automatic logic signed [OUT_W-1:0] map_wrap(input logic signed [ACC_W-1:0] v);
        logic signed [EXT_W-1:0] e;
        e = EXT_W'(v);
        return OUT_W'(e);
    endfunction

`ifdef SINT_SLICE_ACC_SAT_EN
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] map_sat(input logic signed [ACC_W-1:0] v);
        logic signed [EXT_W-1:0] e;
        e = EXT_W'(v);
        if (e > SAT_MAX) begin
            e = SAT_MAX;
        end else if (e < SAT_MIN) begin
            e = SAT_MIN;
        end else begin
            e = e;
        end
        return OUT_W'(e);
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
        logic signed [EXT_W-1:0] e;
        e = EXT_W'(v);
        return (e > SAT_MAX) || (e < SAT_MIN);
    endfunction
`endif

    assign fa_s        = A[LO_A +: SLICE_W];
    assign fb_s        = B[LO_B +: SLICE_W];
    assign term_s      = TERM_W'(fa_s) + TERM_W'(fb_s);
    assign acc_sum_s   = acc_q + ACC_W'(term_s);
    assign unused_in_s = ^{A, B};

    // Next-state, accumulation and result capture.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        xout_d  = xout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (IN_VALID) begin
                    acc_d = acc_sum_s;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = {CNT_W{1'b0}};
`ifdef SINT_SLICE_ACC_SAT_EN
                        xout_d  = map_sat(acc_sum_s);
                        ovf_d   = sat_hit(acc_sum_s);
`else
                        xout_d  = map_wrap(acc_sum_s);
                        ovf_d   = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_HOLD: begin
                // Input side is closed here; only the output handshake moves the FSM.
                if (OUT_READY) begin
                    state_d = ST_ACC;
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACC;
                acc_d   = {ACC_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, accumulator, counter and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_ACC;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            xout_q  <= {OUT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            xout_q  <= xout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign IN_READY  = (state_q == ST_ACC);
    assign OUT_VALID = (state_q == ST_HOLD);
    assign XOUT      = xout_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_sint_slice_acc.sv
// Directed self-checking bench for sint_slice_acc (default COUNT=4 instance plus a COUNT=1 instance).
module tb_sint_slice_acc;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, ovf;
    logic [7:0] a, b;
    logic [3:0] xout;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
    logic [7:0] a1, b1;
    logic [3:0] xout1;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

`ifdef SINT_SLICE_ACC_SAT_EN
    localparam logic [3:0] EXP_X35 = 4'h7;
    localparam logic       EXP_O35 = 1'b1;
    localparam logic [3:0] EXP_X36 = 4'h8;
    localparam logic       EXP_O36 = 1'b1;
    localparam logic [3:0] EXP_X39 = 4'h7;
    localparam logic       EXP_O39 = 1'b1;
`else
    localparam logic [3:0] EXP_X35 = 4'h4;
    localparam logic       EXP_O35 = 1'b0;
    localparam logic [3:0] EXP_X36 = 4'h0;
    localparam logic       EXP_O36 = 1'b0;
    localparam logic [3:0] EXP_X39 = 4'h8;
    localparam logic       EXP_O39 = 1'b0;
`endif

    sint_slice_acc dut (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .A(a), .B(b), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .XOUT(xout), .OVF(ovf)
    );

    sint_slice_acc #(.COUNT(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid1), .IN_READY(in_ready1),
        .A(a1), .B(b1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
        .XOUT(xout1), .OVF(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        tick();
    endtask

    task automatic handshake(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check1({tag, "_hs_ov"}, out_valid, 1'b0);
        check1({tag, "_hs_ir"}, in_ready, 1'b1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
        #12;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check4("rst_xout", xout, 4'h0);
        check1("rst_ovf", ovf, 1'b0);
        check1("rst1_in_ready", in_ready1, 1'b1);
        check1("rst1_out_valid", out_valid1, 1'b0);
        rst_n = 1'b1;

        // Four samples of term 1.
        for (int i = 0; i < 4; i++) begin
            send(8'h01, 8'h00);
            if (i < 3) check1("ones_early_ov", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        check1("ones_ov", out_valid, 1'b1);
        check1("ones_ir", in_ready, 1'b0);
        check4("ones_xout", xout, 4'h4);
        check1("ones_ovf", ovf, 1'b0);
        handshake("ones");

        // Term 5, sum 20: wraps or saturates positive.
        for (int i = 0; i < 4; i++) send(8'h03, 8'h04);
        check1("pos_ov", out_valid, 1'b1);
        check4("pos_xout", xout, EXP_X35);
        check1("pos_ovf", ovf, EXP_O35);

        // Back-pressure: held result stays put while inputs keep arriving.
        in_valid = 1'b1; a = 8'h03; b = 8'h04;
        for (int i = 0; i < 5; i++) begin
            tick();
            check4("hold_xout", xout, EXP_X35);
            check1("hold_ir", in_ready, 1'b0);
            check1("hold_ov", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        check1("hold_rel_ir", in_ready, 1'b1);
        check1("hold_rel_ov", out_valid, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'h01, 8'h00);
            if (i < 3) check1("after_hold_early_ov", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        check1("after_hold_ov", out_valid, 1'b1);
        check4("after_hold_xout", xout, 4'h4);
        check1("after_hold_ovf", ovf, 1'b0);
        handshake("after_hold");

        // Term -16, sum -64: wraps to 0 or saturates negative.
        for (int i = 0; i < 4; i++) send(8'h08, 8'h10);
        in_valid = 1'b0;
        check1("neg_ov", out_valid, 1'b1);
        check4("neg_xout", xout, EXP_X36);
        check1("neg_ovf", ovf, EXP_O36);
        handshake("neg");

        // Mixed-sign terms 6, -1, 1, -3 with an idle gap: sum 3.
        send(8'h07, 8'h1E);
        in_valid = 1'b0;
        tick();
        send(8'h0F, 8'h00);
        send(8'h00, 8'h02);
        check1("mix_early_ov", out_valid, 1'b0);
        send(8'h0A, 8'h06);
        in_valid = 1'b0;
        check1("mix_ov", out_valid, 1'b1);
        check4("mix_xout", xout, 4'h3);
        check1("mix_ovf", ovf, 1'b0);
        handshake("mix");

        // Reset after two accepts discards the partial sum.
        send(8'h01, 8'h00);
        send(8'h01, 8'h00);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check1("midrst_ir", in_ready, 1'b1);
        check1("midrst_ov", out_valid, 1'b0);
        check4("midrst_xout", xout, 4'h0);
        check1("midrst_ovf", ovf, 1'b0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(8'h01, 8'h00);
            if (i < 3) check1("postrst_early_ov", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        check1("postrst_ov", out_valid, 1'b1);
        check4("postrst_xout", xout, 4'h4);
        handshake("postrst");

        // COUNT=1 instance: every accept produces a result.
        in_valid1 = 1'b1; a1 = 8'h07; b1 = 8'h02;
        tick();
        check1("c1_ov", out_valid1, 1'b1);
        check1("c1_ir", in_ready1, 1'b0);
        check4("c1_xout", xout1, EXP_X39);
        check1("c1_ovf", ovf1, EXP_O39);
        out_ready1 = 1'b1;
        tick();
        check1("c1_hs_ov", out_valid1, 1'b0);
        out_ready1 = 1'b0; a1 = 8'h01; b1 = 8'h00;
        tick();
        in_valid1 = 1'b0;
        check1("c1_second_ov", out_valid1, 1'b1);
        check4("c1_second_xout", xout1, 4'h1);
        check1("c1_second_ovf", ovf1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sint_slice_acc.md
SINT_SLICE_ACC -- requirements
Module: sint_slice_acc

Interface
REQ-001 Parameter WIDTH, default 8: bit width of signed inputs A and B.
REQ-002 Parameter SLICE_W, default 4: width of the signed field extracted from each input.
REQ-003 Parameter LO_A, default 0: LSB index of the A field; LO_A+SLICE_W <= WIDTH SHALL hold.
REQ-004 Parameter LO_B, default 1: LSB index of the B field; LO_B+SLICE_W <= WIDTH SHALL hold.
REQ-005 Parameter OUT_W, default 4: width of signed result XOUT.
REQ-006 Parameter COUNT, default 4: accepted samples per result, COUNT >= 1.
REQ-007 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-008 CLK  input  1  rising-edge clock.
REQ-009 RST_N  input  1  asynchronous active-low reset.
REQ-010 IN_VALID  input  1  A/B sample valid.
REQ-011 IN_READY  output  1  block can accept a sample.
REQ-012 A  input  WIDTH signed  operand A.
REQ-013 B  input  WIDTH signed  operand B.
REQ-014 OUT_VALID  output  1  XOUT holds a completed result.
REQ-015 OUT_READY  input  1  consumer accepts XOUT.
REQ-016 XOUT  output  OUT_W signed  accumulated result.
REQ-017 OVF  output  1  result was clamped (saturation build only).

Function
REQ-018 Per sample: fa = A[LO_A+SLICE_W-1:LO_A], fb = B[LO_B+SLICE_W-1:LO_B], each interpreted as signed two's complement.
REQ-019 Term SHALL be sext(fa)+sext(fb) at SLICE_W+1 bits, exact.
REQ-020 Accumulator SHALL be SLICE_W+1+clog2(COUNT) bits signed, never internally overflowing.
REQ-021 FSM states: ACC (IN_READY=1, OUT_VALID=0) and HOLD (IN_READY=0, OUT_VALID=1).
REQ-022 Sample accepted only on rising CLK with IN_VALID=1 and IN_READY=1; accumulator += term, sample counter += 1.
REQ-023 On acceptance of the COUNT-th sample, the FSM SHALL enter HOLD at that edge; OUT_VALID is visible the following cycle (latency 1 cycle).
REQ-024 In HOLD, XOUT and OVF SHALL stay stable until OUT_VALID=1 and OUT_READY=1 at a rising edge.
REQ-025 On the output handshake: return to ACC, accumulator and counter cleared; no sample is accepted in that cycle.
REQ-026 IN_VALID while in HOLD SHALL be ignored (no accumulation, no state change).
REQ-027 Default output mapping: XOUT = low OUT_W bits of the accumulator (two's-complement wrap); OVF = 0.
REQ-028 COUNT=1: every accepted sample SHALL move ACC->HOLD directly.
REQ-029 XOUT SHALL be registered; no combinational path from A/B to XOUT.

Reset
REQ-030 RST_N low SHALL immediately force ACC, accumulator=0, counter=0, XOUT=0, OVF=0, OUT_VALID=0, IN_READY=1.
REQ-031 Reset mid-accumulation or mid-HOLD SHALL discard partial/pending results; the count restarts from 0 after release.

Configuration
REQ-032 Macro SINT_SLICE_ACC_SAT_EN defined: XOUT = accumulator clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; OVF = 1 when clamping occurred, captured together with XOUT.
REQ-033 Macro SINT_SLICE_ACC_SAT_EN undefined: wrap mapping per REQ-027; OVF tied to 0.

Verification (defaults: WIDTH=8, SLICE_W=4, LO_A=0, LO_B=1, OUT_W=4, COUNT=4)
REQ-034 4x (A=8'h01, B=8'h00) -> XOUT=4, OVF=0 in both builds; OUT_VALID rises 1 cycle after the 4th accept.
REQ-035 4x (A=8'h03, B=8'h04): term 5, sum 20 -> wrap build XOUT=4, OVF=0; SAT build XOUT=7, OVF=1.
REQ-036 4x (A=8'h08, B=8'h10): term -16, sum -64 -> wrap build XOUT=0; SAT build XOUT=-8, OVF=1.
REQ-037 Result pending, OUT_READY=0 for 5 cycles with IN_VALID=1 -> XOUT stable, IN_READY=0, nothing accumulated; OUT_READY=1 -> ACC, next result depends only on new samples.
REQ-038 RST_N pulsed low after 2 accepts -> all outputs at reset values; 4 further accepts are needed before OUT_VALID.
REQ-039 COUNT=1, A=8'h07, B=8'h02 (term 8) -> wrap XOUT=-8; SAT XOUT=7, OVF=1.
